multi_pwm: RTL and testbench

Parametrised multi-channel PWM generator controlled by PS/2 set-2 scancodes; successor to the single-channel keyboard-driven PWM stage. It sits on the pixel clock next to the keyboard protocol block, consuming its scancode/valid strobe. Digit keys select a channel and numpad +/- adjust that channel's duty in saturating steps. New duties take effect only at period boundaries, so outputs never glitch.

---
 rtl/multi_pwm.sv | 194 +++++++++++++++++++
 tb/tb_multi_pwm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pwm.sv
// Multi-channel PWM generator driven by PS/2 set-2 scancodes.
// Digit keys pick a channel; numpad +/-, Z and M edit that channel's pending duty.
// Pending duties are copied into the active set only at the period boundary,
// so a PWM output never changes its duty part-way through a period.
module multi_pwm #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flag_i,
    input  logic [7:0]          scancode_i,
    output logic [CHANNELS-1:0] pwm_o,
    output logic [2:0]          sel_o,
    output logic [WIDTH:0]      sel_duty_o,
    output logic                period_start_o
);

    // Duty registers hold 0..2^WIDTH; arithmetic gets one more bit of headroom.
    localparam int unsigned DW = WIDTH + 1;
    localparam int unsigned AW = WIDTH + 2;

    localparam logic [AW-1:0]    FullExt = AW'(1) << WIDTH;
    localparam logic [AW-1:0]    StepExt = AW'(STEP);
    localparam logic [DW-1:0]    StepDw  = DW'(STEP);
    localparam logic [WIDTH-1:0] CntMax  = '1;

    // PS/2 set-2 codes of interest
    localparam logic [7:0] CodeBreak = 8'hF0;
    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeInc   = 8'h79;
    localparam logic [7:0] CodeDec   = 8'h7B;
    localparam logic [7:0] CodeZero  = 8'h1A;
    localparam logic [7:0] CodeMax   = 8'h3A;

    typedef enum logic [0:0] {
        StIdle,
        StBrk
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]             cnt_q, cnt_d;
    logic [2:0]                   sel_q, sel_d;
    logic [CHANNELS-1:0][DW-1:0]  duty_next_q, duty_next_d;
    logic [CHANNELS-1:0][DW-1:0]  duty_act_q, duty_act_d;
    logic [CHANNELS-1:0]          pwm_q, pwm_d;
    logic                         period_start_q, period_start_d;

    logic       make_v;
    logic [2:0] key_ch;
    logic       key_is_sel;
    logic       key_is_inc;
    logic       key_is_dec;
    logic       key_is_zero;
    logic       key_is_max;

    logic [DW-1:0] cur_duty;
    logic [AW-1:0] sum;
    logic [DW-1:0] inc_val;
    logic [DW-1:0] dec_val;
    logic [DW-1:0] new_duty;
    logic          duty_wr;

    // Byte classification of the incoming scancode
    always_comb begin
        key_ch      = 3'd0;
        key_is_sel  = 1'b0;
        key_is_inc  = 1'b0;
        key_is_dec  = 1'b0;
        key_is_zero = 1'b0;
        key_is_max  = 1'b0;
        case (scancode_i)
            8'h16: begin key_ch = 3'd0; key_is_sel = 1'b1; end
            8'h1E: begin key_ch = 3'd1; key_is_sel = 1'b1; end
            8'h26: begin key_ch = 3'd2; key_is_sel = 1'b1; end
            8'h25: begin key_ch = 3'd3; key_is_sel = 1'b1; end
            8'h2E: begin key_ch = 3'd4; key_is_sel = 1'b1; end
            8'h36: begin key_ch = 3'd5; key_is_sel = 1'b1; end
            8'h3D: begin key_ch = 3'd6; key_is_sel = 1'b1; end
            8'h3E: begin key_ch = 3'd7; key_is_sel = 1'b1; end
            CodeInc:  key_is_inc  = 1'b1;
            CodeDec:  key_is_dec  = 1'b1;
            CodeZero: key_is_zero = 1'b1;
            CodeMax:  key_is_max  = 1'b1;
            default: ;
        endcase
    end

    // Decoder FSM: the byte after F0 is a release and is swallowed; E0 prefixes are skipped
    always_comb begin
        state_d = state_q;
        make_v  = 1'b0;
        if (flag_i) begin
            unique case (state_q)
                StIdle: begin
                    if (scancode_i == CodeBreak) begin
                        state_d = StBrk;
                    end else if (scancode_i != CodeExt) begin
                        make_v = 1'b1;
                    end
                end
                StBrk: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Pending duty of the selected channel; also drives sel_duty_o
    always_comb begin
        cur_duty = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (sel_q == 3'(ch)) begin
                cur_duty = duty_next_q[ch];
            end
        end
    end

    // Saturating step arithmetic; decrement is guarded so it never wraps
    always_comb begin
        sum     = AW'(cur_duty) + StepExt;
        inc_val = (sum > FullExt) ? FullExt[DW-1:0] : sum[DW-1:0];
        dec_val = (cur_duty < StepDw) ? '0 : cur_duty - StepDw;

        new_duty = cur_duty;
        if (key_is_inc) begin
            new_duty = inc_val;
        end else if (key_is_dec) begin
            new_duty = dec_val;
        end else if (key_is_zero) begin
            new_duty = '0;
        end else if (key_is_max) begin
            new_duty = FullExt[DW-1:0];
        end
        duty_wr = make_v & (key_is_inc | key_is_dec | key_is_zero | key_is_max);
    end

    // Channel selection and pending-duty update
    always_comb begin
        sel_d       = sel_q;
        duty_next_d = duty_next_q;
        // Codes for channels that do not exist leave the selection alone
        if (make_v && key_is_sel && (32'(key_ch) < CHANNELS)) begin
            sel_d = key_ch;
        end
        if (duty_wr) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                if (sel_q == 3'(ch)) begin
                    duty_next_d[ch] = new_duty;
                end
            end
        end
    end

    // Period counter, boundary load of active duties, and registered compare
    always_comb begin
        cnt_d          = cnt_q + WIDTH'(1);
        period_start_d = (cnt_q == '0);
        // Loading on the last count makes the new duty valid from count 0
        duty_act_d     = (cnt_q == CntMax) ? duty_next_q : duty_act_q;
        pwm_d          = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            pwm_d[ch] = ({1'b0, cnt_q} < duty_act_q[ch]);
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            sel_q          <= 3'd0;
            duty_next_q    <= '0;
            duty_act_q     <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sel_q          <= sel_d;
            duty_next_q    <= duty_next_d;
            duty_act_q     <= duty_act_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_o          = pwm_q;
    assign sel_o          = sel_q;
    assign sel_duty_o     = cur_duty;
    assign period_start_o = period_start_q;

endmodule

// File: tb/tb_multi_pwm.sv
// Bench for multi_pwm (CHANNELS=4, WIDTH=8, STEP=16): keypress vectors with a
// scoreboard queue, plus period measurements of the PWM outputs.
module tb_multi_pwm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flag = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic [3:0] pwm;
    logic [2:0] sel;
    logic [8:0] sel_duty;
    logic       period_start;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] code;
        logic [2:0] sel;
        logic [8:0] duty;
    } vec_t;

    vec_t sb_q[$];
    vec_t vec_inc[4];
    vec_t vec_brk[15];
    vec_t vec_chk[4];

    int meas_hi[4];
    int meas_ps;

    multi_pwm #(
        .CHANNELS(4),
        .WIDTH(8),
        .STEP(16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .flag_i(flag),
        .scancode_i(scancode),
        .pwm_o(pwm),
        .sel_o(sel),
        .sel_duty_o(sel_duty),
        .period_start_o(period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] c, input logic [2:0] s, input logic [8:0] d);
        vec_t v;
        v.code = c;
        v.sel  = s;
        v.duty = d;
        return v;
    endfunction

    // One keypress: expectation queued when driven, popped once the DUT has sampled it
    task automatic send_key(input logic [7:0] code, input logic [2:0] es, input logic [8:0] ed);
        vec_t v;
        sb_q.push_back(mk(code, es, ed));
        @(negedge clk);
        flag = 1'b1;
        scancode = code;
        @(negedge clk);
        flag = 1'b0;
        v = sb_q.pop_front();
        check($sformatf("key %h sel", v.code), int'(sel), int'(v.sel));
        check($sformatf("key %h sel_duty", v.code), int'(sel_duty), int'(v.duty));
    endtask

    task automatic wait_ps();
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (period_start) found = 1'b1;
        end
        if (!found) check("period_start timeout", 0, 1);
    endtask

    // Starts on a period_start sample, collects one full period of 256 samples
    task automatic measure();
        for (int c = 0; c < 4; c++) meas_hi[c] = 0;
        meas_ps = 0;
        for (int i = 0; i < 256; i++) begin
            for (int c = 0; c < 4; c++) meas_hi[c] += int'(pwm[c]);
            meas_ps += int'(period_start);
            @(negedge clk);
        end
    endtask

    initial begin
        vec_inc[0] = mk(8'h16, 3'd0, 9'd0);
        vec_inc[1] = mk(8'h79, 3'd0, 9'd16);
        vec_inc[2] = mk(8'h79, 3'd0, 9'd32);
        vec_inc[3] = mk(8'h79, 3'd0, 9'd48);

        vec_brk[0]  = mk(8'h1E, 3'd1, 9'd0);
        vec_brk[1]  = mk(8'h79, 3'd1, 9'd16);
        vec_brk[2]  = mk(8'hF0, 3'd1, 9'd16);
        vec_brk[3]  = mk(8'h79, 3'd1, 9'd16);
        vec_brk[4]  = mk(8'hF0, 3'd1, 9'd16);
        vec_brk[5]  = mk(8'h1E, 3'd1, 9'd16);
        vec_brk[6]  = mk(8'hE0, 3'd1, 9'd16);
        vec_brk[7]  = mk(8'h79, 3'd1, 9'd32);
        vec_brk[8]  = mk(8'h3D, 3'd1, 9'd32);
        vec_brk[9]  = mk(8'h3A, 3'd1, 9'd256);
        vec_brk[10] = mk(8'h7B, 3'd1, 9'd240);
        vec_brk[11] = mk(8'h1A, 3'd1, 9'd0);
        vec_brk[12] = mk(8'h7B, 3'd1, 9'd0);
        vec_brk[13] = mk(8'h3E, 3'd1, 9'd0);
        vec_brk[14] = mk(8'h22, 3'd1, 9'd0);

        vec_chk[0] = mk(8'h16, 3'd0, 9'd0);
        vec_chk[1] = mk(8'h1E, 3'd1, 9'd0);
        vec_chk[2] = mk(8'h26, 3'd2, 9'd0);
        vec_chk[3] = mk(8'h25, 3'd3, 9'd0);

        // Reset held with keypresses arriving: nothing may move
        #1 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            flag = ~flag;
            scancode = (i < 2) ? 8'h1E : 8'h79;
            check("reset pwm", int'(pwm), 0);
            check("reset sel", int'(sel), 0);
            check("reset sel_duty", int'(sel_duty), 0);
            check("reset period_start", int'(period_start), 0);
        end
        @(negedge clk);
        flag = 1'b0;
        rst_n = 1'b1;

        wait_ps();
        measure();
        check("period_start count per period", meas_ps, 1);
        check("period_start after 256", int'(period_start), 1);
        check("idle pwm high clocks", meas_hi[0] + meas_hi[1] + meas_hi[2] + meas_hi[3], 0);

        // Increment
        foreach (vec_inc[i]) send_key(vec_inc[i].code, vec_inc[i].sel, vec_inc[i].duty);
        wait_ps();
        measure();
        check("ch0 high clocks at 48", meas_hi[0], 48);
        check("ch1 high clocks", meas_hi[1], 0);
        check("ch2 high clocks", meas_hi[2], 0);
        check("ch3 high clocks", meas_hi[3], 0);

        // Saturation and floor on ch2
        send_key(8'h26, 3'd2, 9'd0);
        for (int i = 1; i <= 20; i++) begin
            send_key(8'h79, 3'd2, 9'((i * 16 > 256) ? 256 : i * 16));
        end
        wait_ps();
        measure();
        check("ch2 saturated high clocks", meas_hi[2], 256);
        check("ch0 unchanged high clocks", meas_hi[0], 48);
        for (int i = 1; i <= 20; i++) begin
            send_key(8'h7B, 3'd2, 9'((256 - i * 16 < 0) ? 0 : 256 - i * 16));
        end
        wait_ps();
        measure();
        check("ch2 floored high clocks", meas_hi[2], 0);

        // Break / extended prefix handling, plus Z and M
        foreach (vec_brk[i]) send_key(vec_brk[i].code, vec_brk[i].sel, vec_brk[i].duty);

        // Back-to-back strobes are each processed
        @(negedge clk);
        flag = 1'b1;
        scancode = 8'h79;
        @(negedge clk);
        scancode = 8'h79;
        @(negedge clk);
        flag = 1'b0;
        check("back-to-back sel_duty", int'(sel_duty), 32);

        // Boundary: update on the cnt=255 edge is deferred by one period
        send_key(8'h16, 3'd0, 9'd48);
        send_key(8'h1A, 3'd0, 9'd0);
        for (int i = 1; i <= 4; i++) send_key(8'h79, 3'd0, 9'(i * 16));
        wait_ps();
        repeat (254) @(negedge clk);
        sb_q.push_back(mk(8'h3A, 3'd0, 9'd256));
        flag = 1'b1;
        scancode = 8'h3A;
        @(negedge clk);
        flag = 1'b0;
        begin
            vec_t v;
            v = sb_q.pop_front();
            check("boundary key sel_duty", int'(sel_duty), int'(v.duty));
        end
        wait_ps();
        measure();
        check("boundary period keeps old duty", meas_hi[0], 64);
        measure();
        check("period after boundary full", meas_hi[0], 256);

        // Async reset mid-period with ch0 at 128
        for (int i = 1; i <= 8; i++) send_key(8'h7B, 3'd0, 9'(256 - i * 16));
        wait_ps();
        repeat (99) @(negedge clk);
        check("ch0 high before reset", int'(pwm[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("pwm low on async reset", int'(pwm), 0);
        check("sel_duty cleared on async reset", int'(sel_duty), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vec_chk[i]) send_key(vec_chk[i].code, vec_chk[i].sel, vec_chk[i].duty);
        wait_ps();
        measure();
        check("post-reset high clocks", meas_hi[0] + meas_hi[1] + meas_hi[2] + meas_hi[3], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
